// File: rtl/ps2_kbd_tx_pkg.sv
// Shared definitions for the PS/2 keyboard-side transmitter: frame layout
// constants, the transmit FSM state type and the odd-parity helper.
package ps2_pkg;

   localparam int   FRAME_BITS = 11;
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      BIT_HI = 3'd2,
      BIT_LO = 3'd3,
      GAP    = 3'd4
   } tx_state_t;

   // PS/2 uses odd parity: the parity bit makes the count of ones odd.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Host-facing bus of the PS/2 keyboard transmitter: byte queue port, status
// flags and the two PS/2 lines. PS2_KBD_TX_PARITY_INJ_EN adds inject_perr.
interface ps2_kbd_tx_if;

   logic [7:0] wr_data;
   logic       wr_en;
   logic       full;
   logic       busy;
   logic       overflow;
   logic       ps2_clk;
   logic       ps2_data;
`ifdef PS2_KBD_TX_PARITY_INJ_EN
   logic       inject_perr;

   modport master (output wr_data, wr_en, inject_perr,
                   input  full, busy, overflow, ps2_clk, ps2_data);
   modport slave  (input  wr_data, wr_en, inject_perr,
                   output full, busy, overflow, ps2_clk, ps2_data);
`else
   modport master (output wr_data, wr_en,
                   input  full, busy, overflow, ps2_clk, ps2_data);
   modport slave  (input  wr_data, wr_en,
                   output full, busy, overflow, ps2_clk, ps2_data);
`endif

endinterface

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO holding queued scan codes. Pointers carry one extra
// wrap bit so full and empty are told apart by the pointer MSBs.
module ps2_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2**AW];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Storage array; a push while full is ignored so the oldest data survives.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   // Pointer update; push and pop in the same cycle are both honoured.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard emulator: queues scan codes and sends each as an 11-bit
// device-to-host frame (start, 8 data LSB first, odd parity, stop).
// Optional macro PS2_KBD_TX_PARITY_INJ_EN lets each byte carry a flag that
// flips its parity bit to exercise the receiver's error path.
module ps2_kbd_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV    = 50,
   parameter int GAP_CYCLES = 100,
   parameter int FIFO_AW    = 3
) (
   input  logic         clk,
   input  logic         rst,
   ps2_kbd_tx_if.slave  bus
);

`ifdef PS2_KBD_TX_PARITY_INJ_EN
   localparam int FW = 9;
`else
   localparam int FW = 8;
`endif
   localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   tx_state_t         state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [3:0]        bit_cnt, bit_cnt_n;
   logic [10:0]       shift, shift_n;
   logic              ps2_clk_n, ps2_data_n;
   logic              ps2_clk_q, ps2_data_q;
   logic              overflow_q;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic [FW-1:0]     fifo_din, fifo_dout;
   logic              par_bit;

`ifdef PS2_KBD_TX_PARITY_INJ_EN
   assign fifo_din = {bus.inject_perr, bus.wr_data};
   assign par_bit  = odd_parity(fifo_dout[7:0]) ^ fifo_dout[8];
`else
   assign fifo_din = bus.wr_data;
   assign par_bit  = odd_parity(fifo_dout[7:0]);
`endif

   ps2_tx_fifo #(.WIDTH(FW), .AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.wr_en),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.full     = fifo_full;
   assign bus.busy     = (state != IDLE) || !fifo_empty;
   assign bus.overflow = overflow_q;
   assign bus.ps2_clk  = ps2_clk_q;
   assign bus.ps2_data = ps2_data_q;

   // State, counters, shift register and the registered PS/2 lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_cnt    <= '0;
         shift      <= '1;
         ps2_clk_q  <= 1'b1;
         ps2_data_q <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         bit_cnt    <= bit_cnt_n;
         shift      <= shift_n;
         ps2_clk_q  <= ps2_clk_n;
         ps2_data_q <= ps2_data_n;
         if (bus.wr_en && fifo_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Next-state logic; the line values are decoded from the next state so
   // the output registers always agree with the state they belong to.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      fifo_pop  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               state_n = LOAD;
            end
         end
         LOAD: begin
            shift_n   = {STOP_BIT, par_bit, fifo_dout[7:0], START_BIT};
            fifo_pop  = 1'b1;
            bit_cnt_n = '0;
            cnt_n     = '0;
            state_n   = BIT_HI;
         end
         BIT_HI: begin
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               cnt_n   = '0;
               state_n = BIT_LO;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         BIT_LO: begin
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
               cnt_n     = '0;
               shift_n   = {1'b1, shift[10:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                  state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
               end else begin
                  state_n = BIT_HI;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      ps2_clk_n  = (state_n != BIT_LO);
      ps2_data_n = ((state_n == BIT_HI) || (state_n == BIT_LO)) ? shift_n[0] : 1'b1;
   end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a waveform-level model predicts every
// output on every cycle, and a frame decoder checks the bytes on the wire.
module tb_ps2_kbd_tx;

   localparam int CLK_DIV = 4;
   localparam int GAP     = 8;

   logic clk = 1'b0;
   logic rst;
   logic inj;
   logic inj_eff;
   logic started = 1'b0;

   always #5 clk = ~clk;

   ps2_kbd_tx_if bus ();

`ifdef PS2_KBD_TX_PARITY_INJ_EN
   assign bus.inject_perr = inj;
   assign inj_eff = inj;
`else
   assign inj_eff = 1'b0;
`endif

   ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .FIFO_AW(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a queue of per-cycle expected line values for the frame in flight,
   // a queue for FIFO contents, and the list of frames the wire must carry.
   typedef struct packed {logic c; logic d; logic ld;} wv_t;
   wv_t        wave[$];
   logic [8:0] mfifo[$];
   logic [8:0] exp_rx[$];
   logic       m_ovf = 1'b0;

   task automatic buildFrame(input logic [8:0] e);
      logic [10:0] bits;
      bits = {1'b1, (~^e[7:0]) ^ e[8], e[7:0], 1'b0};
      wave.push_back('{c: 1'b1, d: 1'b1, ld: 1'b1});
      for (int i = 0; i < 11; i++) begin
         for (int k = 0; k < CLK_DIV; k++) wave.push_back('{c: 1'b1, d: bits[i], ld: 1'b0});
         for (int k = 0; k < CLK_DIV; k++) wave.push_back('{c: 1'b0, d: bits[i], ld: 1'b0});
      end
      for (int k = 0; k < GAP; k++) wave.push_back('{c: 1'b1, d: 1'b1, ld: 1'b0});
      exp_rx.push_back(e);
   endtask

   always @(posedge clk) begin : model
      logic pre_full;
      logic do_pop;
      if (rst) begin
         if (wave.size() > GAP + CLK_DIV) void'(exp_rx.pop_back());
         wave.delete();
         mfifo.delete();
         m_ovf = 1'b0;
      end else begin
         pre_full = (mfifo.size() == 8);
         do_pop   = (wave.size() != 0) && wave[0].ld;
         if (wave.size() != 0) void'(wave.pop_front());
         else if (mfifo.size() != 0) buildFrame(mfifo[0]);
         if (do_pop) void'(mfifo.pop_front());
         if (bus.wr_en) begin
            if (!pre_full) mfifo.push_back({inj_eff, bus.wr_data});
            else m_ovf = 1'b1;
         end
      end
   end

   // Decoder state for frames seen on the PS/2 lines.
   logic       prev_c = 1'b1;
   int         nbits = 0;
   int         fall_count = 0;
   int         busy_cnt = 0;
   logic [10:0] cur_bits;
   logic [10:0] last_frame;
   logic [8:0] rx_log[$];

   // Per-cycle compare against the model, plus decoding on each ps2_clk fall.
   always @(negedge clk) begin : monitor
      logic [8:0] rx;
      if (started) begin
         checkOutput("ps2_clk",  bus.ps2_clk,  (wave.size() != 0) ? wave[0].c : 1'b1);
         checkOutput("ps2_data", bus.ps2_data, (wave.size() != 0) ? wave[0].d : 1'b1);
         checkOutput("busy",     bus.busy,     (wave.size() != 0) || (mfifo.size() != 0));
         checkOutput("full",     bus.full,     mfifo.size() == 8);
         checkOutput("overflow", bus.overflow, m_ovf);
         if (bus.busy === 1'b1) busy_cnt++;
         if (prev_c === 1'b1 && bus.ps2_clk === 1'b0) begin
            cur_bits[nbits] = bus.ps2_data;
            nbits++;
            fall_count++;
            if (nbits == 11) begin
               nbits      = 0;
               last_frame = cur_bits;
               rx = {~(^cur_bits[9:1]), cur_bits[8:1]};
               checkOutput("start_bit", cur_bits[0], 1'b0);
               checkOutput("stop_bit",  cur_bits[10], 1'b1);
               rx_log.push_back(rx);
               if (exp_rx.size() == 0) begin
                  checkOutput("unexpected_frame", rx, 9'h1ff);
               end else begin
                  checkOutput("rx_byte", rx, exp_rx.pop_front());
               end
            end
         end
         if (rst) nbits = 0;
      end
      prev_c = bus.ps2_clk;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic perr);
      bus.wr_en   = 1'b1;
      bus.wr_data = b;
      inj         = perr;
      tick();
      bus.wr_en   = 1'b0;
      inj         = 1'b0;
   endtask

   task automatic waitIdle(input int max_cycles);
      int n;
      n = 0;
      tick();
      while (bus.busy && n < max_cycles) begin
         tick();
         n++;
      end
      checkOutput("idle_timeout", bus.busy, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int n;
      int k;
      rst = 1'b1;
      bus.wr_en = 1'b0;
      bus.wr_data = 8'h00;
      inj = 1'b0;
      tick();
      started = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      checkOutput("reset_ps2_clk",  bus.ps2_clk,  1'b1);
      checkOutput("reset_ps2_data", bus.ps2_data, 1'b1);
      checkOutput("reset_busy",     bus.busy,     1'b0);
      checkOutput("reset_full",     bus.full,     1'b0);
      checkOutput("reset_overflow", bus.overflow, 1'b0);

      $display("[TB] single byte 0x1C");
      fall_count = 0;
      busy_cnt   = 0;
      rx_log.delete();
      applyStimulus(8'h1C, 1'b0);
      waitIdle(400);
      checkOutput("single_falls", fall_count, 11);
      checkOutput("single_bits",  last_frame, 11'b10000111000);
      checkOutput("single_busy_cycles", busy_cnt, 1 + 1 + 22 * CLK_DIV + GAP);
      checkOutput("single_rx_count", rx_log.size(), 1);
      repeat (5) tick();
      checkOutput("single_idle_clk", bus.ps2_clk, 1'b1);

      $display("[TB] fifo overflow");
      rx_log.delete();
      applyStimulus(8'hE0, 1'b0);
      repeat (3) tick();
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(8'(i), 1'b0);
         if (i == 7) checkOutput("ovf_not_full_7", bus.full, 1'b0);
         if (i == 8) checkOutput("ovf_full_8", bus.full, 1'b1);
         if (i == 8) checkOutput("ovf_clear_8", bus.overflow, 1'b0);
         if (i == 9) checkOutput("ovf_set_9", bus.overflow, 1'b1);
      end
      waitIdle(2000);
      checkOutput("ovf_rx_count", rx_log.size(), 9);
      for (int i = 0; i < 9 && i < rx_log.size(); i++) begin
         checkOutput("ovf_rx_order", rx_log[i], (i == 0) ? 9'h0E0 : 9'(i));
      end

      $display("[TB] reset mid-frame");
      rx_log.delete();
      fall_count = 0;
      applyStimulus(8'hAA, 1'b0);
      n = 0;
      while (fall_count < 5 && n < 300) begin
         tick();
         n++;
      end
      checkOutput("midreset_reach_bit4", fall_count, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midreset_clk",      bus.ps2_clk,  1'b1);
      checkOutput("midreset_data",     bus.ps2_data, 1'b1);
      checkOutput("midreset_busy",     bus.busy,     1'b0);
      checkOutput("midreset_overflow", bus.overflow, 1'b0);
      applyStimulus(8'h55, 1'b0);
      waitIdle(400);
      checkOutput("midreset_rx_count", rx_log.size(), 1);
      if (rx_log.size() == 1) checkOutput("midreset_rx_55", rx_log[0], 9'h055);

      $display("[TB] push during LOAD");
      rx_log.delete();
      applyStimulus(8'h3A, 1'b0);
      tick();
      applyStimulus(8'h5B, 1'b0);
      checkOutput("pushpop_busy", bus.busy, 1'b1);
      waitIdle(600);
      checkOutput("pushpop_rx_count", rx_log.size(), 2);
      if (rx_log.size() == 2) begin
         checkOutput("pushpop_first",  rx_log[0], 9'h03A);
         checkOutput("pushpop_second", rx_log[1], 9'h05B);
      end

`ifdef PS2_KBD_TX_PARITY_INJ_EN
      $display("[TB] parity injection");
      rx_log.delete();
      applyStimulus(8'h1C, 1'b1);
      applyStimulus(8'h32, 1'b0);
      waitIdle(600);
      checkOutput("perr_rx_count", rx_log.size(), 2);
      if (rx_log.size() == 2) begin
         checkOutput("perr_bad_frame",  rx_log[0], 9'h11C);
         checkOutput("perr_good_frame", rx_log[1], 9'h032);
      end
      checkOutput("perr_last_parity", last_frame[9], 1'b0);
`endif

      $display("[TB] randomized traffic");
      for (int it = 0; it < 40; it++) begin
         n = $urandom_range(0, 150);
         repeat (n) tick();
         k = ($urandom_range(0, 9) == 0) ? 11 : $urandom_range(1, 3);
         for (int j = 0; j < k; j++) begin
            applyStimulus(8'($urandom), 1'($urandom_range(0, 3) == 0));
         end
      end
      waitIdle(3000);
      checkOutput("final_exp_empty", exp_rx.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
